// File: rtl/sc_reg_nest_tracker.sv
// ============================================================================
// sc_reg_nest_tracker : nest-occupancy bitmap with count, dup/bad rejection,
//                       all-full flag and optional timed auto-clear.
// Rev 1.0
// ============================================================================
`default_nettype none

module sc_reg_nest_tracker #(
    parameter int                    NUM_NESTS   = 5,
    parameter int                    IDX_WIDTH   = 3,
    parameter int                    CNT_WIDTH   = 3,
    parameter int                    AUTO_CLEAR  = 1,
    parameter int                    HOLD_CYCLES = 8,
    parameter logic [NUM_NESTS-1:0]  INIT_MAP    = '0
) (
    input  logic                  NestTrk_CLOCK_50,
    input  logic                  NestTrk_RESET_InLow,
    input  logic                  NestTrk_clear_InLow,
    input  logic                  NestTrk_load_InLow,
    input  logic [NUM_NESTS-1:0]  NestTrk_map_InBUS,
    input  logic                  NestTrk_reached_InLow,
    input  logic [IDX_WIDTH-1:0]  NestTrk_idx_InBUS,
    output logic [NUM_NESTS-1:0]  NestTrk_map_OutBUS,
    output logic [CNT_WIDTH-1:0]  NestTrk_count_OutBUS,
    output logic                  NestTrk_full_OutLow,
    output logic                  NestTrk_done_OutHigh,
    output logic                  NestTrk_dup_OutHigh,
    output logic                  NestTrk_bad_OutHigh
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {
        FILLING   = 1'b0,
        FULL_HOLD = 1'b1
    } state_t;

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [NUM_NESTS-1:0] idx_onehot;
    logic [NUM_NESTS-1:0] set_map;
    logic                 idx_bad;
    logic                 idx_dup;

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [NUM_NESTS-1:0] m);
        logic [CNT_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_NESTS; i++) begin
            c = c + {{(CNT_WIDTH-1){1'b0}}, m[i]};
        end
        return c;
    endfunction

    // Decoding the index into a one-hot keeps out-of-range indices from ever
    // addressing the bitmap; an all-zero decode is exactly the "bad" case.
    always_comb begin
        idx_onehot = '0;
        for (int i = 0; i < NUM_NESTS; i++) begin
            if (NestTrk_idx_InBUS == IDX_WIDTH'(i)) begin
                idx_onehot[i] = 1'b1;
            end
        end
    end

    assign idx_bad = ~|idx_onehot;
    assign idx_dup = |(idx_onehot & NestTrk_map_OutBUS);
    assign set_map = NestTrk_map_OutBUS | idx_onehot;

    always_ff @(posedge NestTrk_CLOCK_50 or negedge NestTrk_RESET_InLow) begin
        if (!NestTrk_RESET_InLow) begin
            state                <= FILLING;
            hold_cnt             <= '0;
            NestTrk_map_OutBUS   <= '0;
            NestTrk_count_OutBUS <= '0;
            NestTrk_full_OutLow  <= 1'b1;
            NestTrk_done_OutHigh <= 1'b0;
            NestTrk_dup_OutHigh  <= 1'b0;
            NestTrk_bad_OutHigh  <= 1'b0;
        end else begin
            NestTrk_done_OutHigh <= 1'b0;
            NestTrk_dup_OutHigh  <= 1'b0;
            NestTrk_bad_OutHigh  <= 1'b0;

            if (!NestTrk_clear_InLow) begin
                state                <= FILLING;
                hold_cnt             <= '0;
                NestTrk_map_OutBUS   <= INIT_MAP;
                NestTrk_count_OutBUS <= popcount(INIT_MAP);
                NestTrk_full_OutLow  <= ~(&INIT_MAP);
            end else if (!NestTrk_load_InLow) begin
                state                <= (&NestTrk_map_InBUS) ? FULL_HOLD : FILLING;
                hold_cnt             <= '0;
                NestTrk_map_OutBUS   <= NestTrk_map_InBUS;
                NestTrk_count_OutBUS <= popcount(NestTrk_map_InBUS);
                NestTrk_full_OutLow  <= ~(&NestTrk_map_InBUS);
            end else begin
                case (state)
                    FILLING: begin
                        if (!NestTrk_reached_InLow) begin
                            if (idx_bad) begin
                                NestTrk_bad_OutHigh <= 1'b1;
                            end else if (idx_dup) begin
                                NestTrk_dup_OutHigh <= 1'b1;
                            end else begin
                                NestTrk_map_OutBUS   <= set_map;
                                NestTrk_count_OutBUS <= NestTrk_count_OutBUS + CNT_WIDTH'(1);
                                if (&set_map) begin
                                    NestTrk_done_OutHigh <= 1'b1;
                                    NestTrk_full_OutLow  <= 1'b0;
                                    state                <= FULL_HOLD;
                                    hold_cnt             <= '0;
                                end
                            end
                        end
                    end
                    FULL_HOLD: begin
                        // Arrivals are swallowed here; only the hold timer acts.
                        if (AUTO_CLEAR != 0) begin
                            if (hold_cnt == HOLD_LAST) begin
                                state                <= FILLING;
                                hold_cnt             <= '0;
                                NestTrk_map_OutBUS   <= INIT_MAP;
                                NestTrk_count_OutBUS <= popcount(INIT_MAP);
                                NestTrk_full_OutLow  <= ~(&INIT_MAP);
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                    end
                    default: begin
                        state    <= FILLING;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sc_reg_nest_tracker.sv
// ============================================================================
// tb_sc_reg_nest_tracker : directed vector table plus reset-in-hold sequence.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sc_reg_nest_tracker;

    logic       clk;
    logic       rst_n;
    logic       clear_n;
    logic       load_n;
    logic [4:0] map_in;
    logic       reached_n;
    logic [2:0] idx;
    logic [4:0] map_out;
    logic [2:0] count_out;
    logic       full_n;
    logic       done;
    logic       dup;
    logic       bad;

    int vec_cnt = 0;
    int err_cnt = 0;

    sc_reg_nest_tracker #(
        .NUM_NESTS   (5),
        .IDX_WIDTH   (3),
        .CNT_WIDTH   (3),
        .AUTO_CLEAR  (1),
        .HOLD_CYCLES (8),
        .INIT_MAP    (5'b00000)
    ) dut (
        .NestTrk_CLOCK_50      (clk),
        .NestTrk_RESET_InLow   (rst_n),
        .NestTrk_clear_InLow   (clear_n),
        .NestTrk_load_InLow    (load_n),
        .NestTrk_map_InBUS     (map_in),
        .NestTrk_reached_InLow (reached_n),
        .NestTrk_idx_InBUS     (idx),
        .NestTrk_map_OutBUS    (map_out),
        .NestTrk_count_OutBUS  (count_out),
        .NestTrk_full_OutLow   (full_n),
        .NestTrk_done_OutHigh  (done),
        .NestTrk_dup_OutHigh   (dup),
        .NestTrk_bad_OutHigh   (bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       clear_n;
        logic       load_n;
        logic       reached_n;
        logic [2:0] idx;
        logic [4:0] map_in;
        logic [4:0] exp_map;
        logic [2:0] exp_cnt;
        logic       exp_full;
        logic       exp_done;
        logic       exp_dup;
        logic       exp_bad;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic c, logic l, logic r, logic [2:0] i,
                                logic [4:0] mi, logic [4:0] em, logic [2:0] ec,
                                logic ef, logic ed, logic eu, logic eb);
        vec_t v;
        v.name = n; v.clear_n = c; v.load_n = l; v.reached_n = r; v.idx = i;
        v.map_in = mi; v.exp_map = em; v.exp_cnt = ec; v.exp_full = ef;
        v.exp_done = ed; v.exp_dup = eu; v.exp_bad = eb;
        return v;
    endfunction

    task automatic check(string n, logic [4:0] em, logic [2:0] ec,
                         logic ef, logic ed, logic eu, logic eb);
        vec_cnt++;
        if (map_out !== em || count_out !== ec || full_n !== ef ||
            done !== ed || dup !== eu || bad !== eb) begin
            err_cnt++;
            $display("FAIL %s: got map=%b cnt=%0d full_n=%b done=%b dup=%b bad=%b, want map=%b cnt=%0d full_n=%b done=%b dup=%b bad=%b",
                     n, map_out, count_out, full_n, done, dup, bad, em, ec, ef, ed, eu, eb);
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        clear_n   = v.clear_n;
        load_n    = v.load_n;
        reached_n = v.reached_n;
        idx       = v.idx;
        map_in    = v.map_in;
        @(posedge clk);
        #1;
        check(v.name, v.exp_map, v.exp_cnt, v.exp_full, v.exp_done, v.exp_dup, v.exp_bad);
    endtask

    initial begin
        rst_n = 1'b0; clear_n = 1'b1; load_n = 1'b1; reached_n = 1'b1;
        idx = 3'd0; map_in = 5'b00000;

        // Fill from empty, then sit in the 8-cycle hold with ignored arrivals.
        vecs.push_back(mk("fill0", 1,1,0,3'd0,5'b0,     5'b00001,3'd1,1,0,0,0));
        vecs.push_back(mk("fill1", 1,1,0,3'd1,5'b0,     5'b00011,3'd2,1,0,0,0));
        vecs.push_back(mk("fill2", 1,1,0,3'd2,5'b0,     5'b00111,3'd3,1,0,0,0));
        vecs.push_back(mk("fill3", 1,1,0,3'd3,5'b0,     5'b01111,3'd4,1,0,0,0));
        vecs.push_back(mk("fill4", 1,1,0,3'd4,5'b0,     5'b11111,3'd5,0,1,0,0));
        vecs.push_back(mk("hold1", 1,1,0,3'd0,5'b0,     5'b11111,3'd5,0,0,0,0));
        vecs.push_back(mk("hold2", 1,1,0,3'd6,5'b0,     5'b11111,3'd5,0,0,0,0));
        vecs.push_back(mk("hold3", 1,1,1,3'd0,5'b0,     5'b11111,3'd5,0,0,0,0));
        vecs.push_back(mk("hold4", 1,1,0,3'd2,5'b0,     5'b11111,3'd5,0,0,0,0));
        vecs.push_back(mk("hold5", 1,1,1,3'd0,5'b0,     5'b11111,3'd5,0,0,0,0));
        vecs.push_back(mk("hold6", 1,1,1,3'd0,5'b0,     5'b11111,3'd5,0,0,0,0));
        vecs.push_back(mk("hold7", 1,1,0,3'd7,5'b0,     5'b11111,3'd5,0,0,0,0));
        vecs.push_back(mk("aclr",  1,1,1,3'd0,5'b0,     5'b00000,3'd0,1,0,0,0));
        // Duplicate and out-of-range arrivals.
        vecs.push_back(mk("r2",    1,1,0,3'd2,5'b0,     5'b00100,3'd1,1,0,0,0));
        vecs.push_back(mk("dup2",  1,1,0,3'd2,5'b0,     5'b00100,3'd1,1,0,1,0));
        vecs.push_back(mk("bad6",  1,1,0,3'd6,5'b0,     5'b00100,3'd1,1,0,0,1));
        vecs.push_back(mk("bad5",  1,1,0,3'd5,5'b0,     5'b00100,3'd1,1,0,0,1));
        // Priority: clear beats load beats reached, and losers give no pulses.
        vecs.push_back(mk("prio",  0,0,0,3'd6,5'b11111, 5'b00000,3'd0,1,0,0,0));
        vecs.push_back(mk("ldful", 1,0,0,3'd1,5'b11111, 5'b11111,3'd5,0,0,0,0));
        vecs.push_back(mk("ldpart",1,0,1,3'd0,5'b01010, 5'b01010,3'd2,1,0,0,0));
        vecs.push_back(mk("ldwin", 1,0,0,3'd3,5'b00000, 5'b00000,3'd0,1,0,0,0));
        vecs.push_back(mk("r3",    1,1,0,3'd3,5'b0,     5'b01000,3'd1,1,0,0,0));
        vecs.push_back(mk("idle",  1,1,1,3'd4,5'b0,     5'b01000,3'd1,1,0,0,0));

        repeat (2) @(posedge clk);
        #1;
        check("reset", 5'b00000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Asynchronous reset while holding full: outputs drop before any edge.
        apply(mk("ldhold", 1,0,1,3'd0,5'b11111, 5'b11111,3'd5,0,0,0,0));
        apply(mk("inhold", 1,1,1,3'd0,5'b0,     5'b11111,3'd5,0,0,0,0));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", 5'b00000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk("pr_f0", 1,1,0,3'd4,5'b0, 5'b10000,3'd1,1,0,0,0));
        apply(mk("pr_f1", 1,1,0,3'd0,5'b0, 5'b10001,3'd2,1,0,0,0));
        apply(mk("pr_f2", 1,1,0,3'd2,5'b0, 5'b10101,3'd3,1,0,0,0));
        apply(mk("pr_f3", 1,1,0,3'd1,5'b0, 5'b10111,3'd4,1,0,0,0));
        apply(mk("pr_f4", 1,1,0,3'd3,5'b0, 5'b11111,3'd5,0,1,0,0));
        apply(mk("pr_h1", 1,1,1,3'd0,5'b0, 5'b11111,3'd5,0,0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
